adaptor_pic_spi_target: RTL and testbench
=========================================

# adaptor_pic_spi_target

Responder (slave) end of the adaptor-board PIC SPI link. It samples the SPI master's SC/CS/DI pins into the 125 MHz system domain and deserialises each 16-bit frame MSB-first. It shifts a locally supplied 16-bit response word out on DO and flags good or malformed frames. It is used as a PIC stand-in for board bring-up and hardware-in-the-loop test, and as the bench model for the SPI master.

## Interface
Parameters:
- `WORD_W`, 16, frame length in bits.
- `SYNC_STAGES`, 2, flip-flop stages on each pin input (minimum 2).
- `FILTER_LEN`, 4, number of consecutive identical samples required by the glitch filter. Used only when the filter is compiled in.

Ports:
- `i_clk`, in, 1, 125 MHz system (AXI) clock.
- `i_rst_n`, in, 1, reset. Synchronous, active-low.
- `i_PIC_SC`, in, 1, SPI serial clock from the master. Idles high.
- `i_PIC_CS`, in, 1, SPI chip select from the master. Active low.
- `i_PIC_DI`, in, 1, master-to-target data.
- `o_PIC_DO`, out, 1, target-to-master data.
- `i_tx_data`, in, WORD_W, response word. Captured at CS fall.
- `o_rx_data`, out, WORD_W, last correctly framed received word.
- `o_rx_valid`, out, 1, one-cycle pulse when `o_rx_data` updates.
- `o_frame_err`, out, 1, one-cycle pulse when a frame ends with a bit count other than WORD_W.
- `o_busy`, out, 1, high while in SHIFT.

## Operation
- Each pin passes through SYNC_STAGES flip-flops and then an edge detector. Synchroniser reset values: SC=1, CS=1, DI=0.
- Reset values of all outputs: `o_PIC_DO`=0, `o_rx_data`=0, `o_rx_valid`=0, `o_frame_err`=0, `o_busy`=0. State on reset is WAIT_IDLE.
- WAIT_IDLE: ignore all pin activity. Go to IDLE once synchronised CS=1. This means a reset released mid-frame never produces a partial frame.
- IDLE: `o_PIC_DO`=0.
  - On CS fall: load tx_shift with `i_tx_data`; bit_cnt=0; rx_shift=0; drive `o_PIC_DO`=`i_tx_data[WORD_W-1]`; go to SHIFT.
- SHIFT:
  - SC fall: rx_shift is shifted left with DI entering the LSB. bit_cnt increments and saturates at WORD_W+1.
  - SC rise with bit_cnt>0: shift tx_shift left and drive `o_PIC_DO` from the new MSB, or 0 once bit_cnt≥WORD_W.
  - CS rise with bit_cnt==WORD_W: `o_rx_data`<=rx_shift and pulse `o_rx_valid`.
  - CS rise with any other bit_cnt: pulse `o_frame_err`; `o_rx_data` is unchanged.
  - After either CS-rise case: `o_PIC_DO`=0 and go to IDLE.
- Simultaneous events: a CS rise in the same cycle as an SC edge completes the frame. The SC edge is ignored.
- An SC edge while CS is high is ignored.
- `i_tx_data` changes after CS fall do not affect the frame in progress.

## Timing
- Pin-to-edge-detect latency: SYNC_STAGES+1 cycles. With the filter compiled in it is SYNC_STAGES+FILTER_LEN+1 cycles.
- DO update lag after a pin SC rise is the same latency L. This requires each SC half period to be ≥ L+2 cycles. At the 50 kHz link rate (1250-cycle half period) the margin is large.
- `o_rx_valid` / `o_frame_err` assert exactly L cycles after the pin CS rise. They are high for one cycle.
- Back-to-back frames need ≥ L+1 cycles of CS high between them.

## Configuration
- `PIC_SPI_TGT_GLITCH_FILTER_EN` defined: each synchronised pin updates its filtered value only after FILTER_LEN consecutive identical samples. Shorter pulses are rejected.
- Not defined: the filtered value is the synchronised value. FILTER_LEN is unused.

## Structure
- Shared package `adaptor_pic_spi_pkg` holds:
  - WORD_W default;
  - state enum {WAIT_IDLE, IDLE, SHIFT};
  - bit-count width constant, $clog2(WORD_W+2).
- Sub-module `pic_spi_pin_cond` contains the synchroniser, optional filter and rise/fall detector. It is instantiated once per pin (SC, CS, DI; the DI edge outputs are unused).

## Test plan
All scenarios use an SC half period of 16 cycles unless stated.
- Nominal frame: `i_tx_data`=0xA5C3 and master sends 0x1234 → `o_rx_data`=0x1234 with one `o_rx_valid` pulse; master samples 0xA5C3; `o_frame_err`=0.
- Short frame: CS raised after 9 SC falls → `o_frame_err` pulses once; `o_rx_data` keeps the previous value 0x1234.
- Long frame: 18 SC falls before CS rise → `o_frame_err` pulse; next 16-bit frame 0xFFFF is received correctly.
- Reset mid-frame: `i_rst_n` low for 3 cycles after 5 bits, then released with CS still low → no valid and no error for that frame; next full frame 0x00FF is received.
- Glitch (macro defined, FILTER_LEN=4): 2-cycle low pulse on SC during a frame → no bit counted; frame 0x8001 is received intact. With the macro undefined, the same stimulus → `o_frame_err`.
- Back-to-back: two frames 0x0F0F then 0xF0F0, separated by L+1 cycles of CS high → two `o_rx_valid` pulses with correct data.

Source files
------------

// File: rtl/adaptor_pic_spi_pkg.sv
// Purpose: shared types and constants for the adaptor-board PIC SPI target.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default frame width, FSM state enum, bit-counter width helpers.
package adaptor_pic_spi_pkg;

  localparam int WORD_W_DEF = 16;

  // The bit counter must hold WORD_W+1, so an overlong frame stays
  // distinguishable from a correct one.
  localparam int BIT_CNT_W = $clog2(WORD_W_DEF + 2);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  function automatic int bit_cnt_width(input int word_w);
    return $clog2(word_w + 2);
  endfunction

endpackage

// File: rtl/pic_spi_pin_cond.sv
// Purpose: condition one asynchronous SPI pin: synchroniser, optional glitch filter, edge detect.
// Latency: edge pulses appear SYNC_STAGES (+FILTER_LEN when filtered) cycles after the pin changes.
// Backpressure: none; free-running sampler.
// Ports: i_clk, i_rst_n (sync, active-low), i_pin (async pin), o_level (conditioned level),
//        o_rise/o_fall (one-cycle edge strobes), o_settled (reset values flushed from the pipeline).
// Macro: PIC_SPI_TGT_GLITCH_FILTER_EN compiles in the FILTER_LEN-sample glitch filter.
module pic_spi_pin_cond #(
  parameter int   SYNC_STAGES = 2,
  parameter int   FILTER_LEN  = 4,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_settled
);

`ifdef PIC_SPI_TGT_GLITCH_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  // Cycles until every stage holding a reset value has been overwritten
  // by a real pin sample.
  localparam int FILT_DEPTH = FILTER_EN ? FILTER_LEN : 0;
  localparam int SETTLE_CYC = SYNC_STAGES + FILT_DEPTH;
  localparam int SETTLE_W   = $clog2(SETTLE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   filt;
  logic                   prev_q;
  logic [SETTLE_W-1:0]    settle_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_pin};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PIC_SPI_TGT_GLITCH_FILTER_EN
  localparam int FCNT_W = $clog2(FILTER_LEN + 1);

  logic [FCNT_W-1:0] fcnt_q;
  logic              filt_q;

  // Count consecutive samples that disagree with the filtered level; any
  // agreeing sample restarts the run, so short pulses never get through.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      filt_q <= RST_VAL;
      fcnt_q <= '0;
    end else if (synced == filt_q) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FCNT_W'(FILTER_LEN - 1)) begin
      filt_q <= synced;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign filt = filt_q;
`else
  assign filt = synced;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_q   <= RST_VAL;
      settle_q <= '0;
    end else begin
      prev_q <= filt;
      if (settle_q != SETTLE_W'(SETTLE_CYC)) begin
        settle_q <= settle_q + 1'b1;
      end
    end
  end

  assign o_level   = filt;
  assign o_rise    = filt & ~prev_q;
  assign o_fall    = ~filt & prev_q;
  assign o_settled = (settle_q == SETTLE_W'(SETTLE_CYC));

endmodule

// File: rtl/adaptor_pic_spi_target.sv
// Purpose: SPI responder standing in for the adaptor-board PIC; deserialises WORD_W-bit frames MSB-first.
// Latency: rx_valid/frame_err and DO updates land SYNC_STAGES+1 cycles (+FILTER_LEN if filtered) after the pin edge.
// Backpressure: none; the master owns the link, results are one-cycle strobes that must be taken when seen.
// Ports: i_clk, i_rst_n (sync, active-low); i_PIC_SC/i_PIC_CS/i_PIC_DI pins in, o_PIC_DO pin out;
//        i_tx_data response word (captured at CS fall); o_rx_data/o_rx_valid received word;
//        o_frame_err bad-length strobe; o_busy high during a frame.
// Macro: PIC_SPI_TGT_GLITCH_FILTER_EN enables the per-pin glitch filter.
module adaptor_pic_spi_target
  import adaptor_pic_spi_pkg::*;
#(
  parameter int WORD_W      = WORD_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_PIC_SC,
  input  logic              i_PIC_CS,
  input  logic              i_PIC_DI,
  output logic              o_PIC_DO,
  input  logic [WORD_W-1:0] i_tx_data,
  output logic [WORD_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  output logic              o_frame_err,
  output logic              o_busy
);

  localparam int CNT_W = (WORD_W == WORD_W_DEF) ? BIT_CNT_W : bit_cnt_width(WORD_W);

  logic sc_level, sc_rise, sc_fall, sc_settled;
  logic cs_level, cs_rise, cs_fall, cs_settled;
  logic di_level, di_rise, di_fall, di_settled;

  // Pin idle levels: SC and CS high, DI low.
  pic_spi_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_sc (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_PIC_SC),
    .o_level(sc_level), .o_rise(sc_rise), .o_fall(sc_fall), .o_settled(sc_settled)
  );

  pic_spi_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RST_VAL(1'b1)) u_cs (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_PIC_CS),
    .o_level(cs_level), .o_rise(cs_rise), .o_fall(cs_fall), .o_settled(cs_settled)
  );

  pic_spi_pin_cond #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .RST_VAL(1'b0)) u_di (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pin(i_PIC_DI),
    .o_level(di_level), .o_rise(di_rise), .o_fall(di_fall), .o_settled(di_settled)
  );

  // Only the CS settle flag and the DI level drive the FSM.
  logic unused_pins;
  assign unused_pins = &{1'b0, sc_level, sc_settled, di_rise, di_fall, di_settled};

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0] tx_shift_q, tx_shift_d;
  logic              do_q, do_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      do_q        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      do_q        <= do_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    do_d        = do_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      // The synchroniser comes out of reset claiming CS is high. Wait until
      // the reset values have been flushed and CS is genuinely high, so a
      // reset released mid-frame cannot start a partial frame.
      WAIT_IDLE: begin
        do_d = 1'b0;
        if (cs_settled && cs_level) begin
          state_d = IDLE;
        end
      end

      IDLE: begin
        do_d = 1'b0;
        if (cs_fall) begin
          tx_shift_d = i_tx_data;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          do_d       = i_tx_data[WORD_W-1];
          state_d    = SHIFT;
        end
      end

      SHIFT: begin
        // CS rise takes priority; an SC edge in the same cycle is dropped.
        if (cs_rise) begin
          if (bit_cnt_q == CNT_W'(WORD_W)) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          do_d    = 1'b0;
          state_d = IDLE;
        end else if (sc_fall) begin
          rx_shift_d = {rx_shift_q[WORD_W-2:0], di_level};
          // Saturate one past WORD_W so overlong frames stay flagged.
          if (bit_cnt_q != CNT_W'(WORD_W + 1)) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sc_rise && (bit_cnt_q != '0)) begin
          tx_shift_d = {tx_shift_q[WORD_W-2:0], 1'b0};
          do_d       = (bit_cnt_q >= CNT_W'(WORD_W)) ? 1'b0 : tx_shift_q[WORD_W-2];
        end
      end

      default: begin
        state_d = WAIT_IDLE;
      end
    endcase
  end

  assign o_PIC_DO    = do_q;
  assign o_rx_data   = rx_data_q;
  assign o_rx_valid  = rx_valid_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_adaptor_pic_spi_target.sv
// Purpose: self-checking bench for adaptor_pic_spi_target driving it as an SPI master.
// Latency: expects result strobes exactly LAT cycles after the CS rise.
// Backpressure: n/a.
module tb_adaptor_pic_spi_target;

  localparam int WORD_W = 16;
  localparam int HALF   = 16;
`ifdef PIC_SPI_TGT_GLITCH_FILTER_EN
  localparam int LAT = 2 + 4 + 1;
`else
  localparam int LAT = 2 + 1;
`endif

  logic              i_clk = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_PIC_SC = 1'b1;
  logic              i_PIC_CS = 1'b1;
  logic              i_PIC_DI = 1'b0;
  logic              o_PIC_DO;
  logic [WORD_W-1:0] i_tx_data = '0;
  logic [WORD_W-1:0] o_rx_data;
  logic              o_rx_valid;
  logic              o_frame_err;
  logic              o_busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: the last word accepted by a correctly framed transfer.
  logic [WORD_W-1:0] exp_rx = '0;

  adaptor_pic_spi_target dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_PIC_SC(i_PIC_SC), .i_PIC_CS(i_PIC_CS), .i_PIC_DI(i_PIC_DI), .o_PIC_DO(o_PIC_DO),
    .i_tx_data(i_tx_data), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  always #4 i_clk = ~i_clk;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // One master transfer. nfalls SC falling edges are issued; with simul_end the
  // last fall coincides with the CS rise. glitch inserts a 2-cycle SC low pulse
  // after the 8th bit. rst_at >= 0 pulses reset for 3 cycles before that bit.
  // obs is the number of cycles watched (with CS high) after the CS rise.
  task automatic run_frame(input logic [WORD_W-1:0] tx, input logic [WORD_W-1:0] rx_word,
                           input int nfalls, input bit glitch, input bit simul_end,
                           input int rst_at, input int obs,
                           output logic [WORD_W-1:0] do_word, output bit do_tail_zero,
                           output bit busy_ok, output int nvalid, output int nerr,
                           output int first_off);
    do_word = '0; do_tail_zero = 1'b1; busy_ok = 1'b1;
    i_tx_data = tx;
    i_PIC_CS  = 1'b0;
    wait_cyc(LAT + 2);
    i_tx_data = WORD_W'($urandom);   // must not disturb the frame in progress
    wait_cyc(HALF - LAT - 2);
    for (int b = 0; b < nfalls; b++) begin
      if (b == rst_at) begin
        i_rst_n = 1'b0;
        wait_cyc(3);
        i_rst_n = 1'b1;
      end
      i_PIC_DI = (b < WORD_W) ? rx_word[WORD_W-1-b] : 1'($urandom_range(0, 1));
      wait_cyc(HALF / 2);
      if (b < WORD_W) do_word[WORD_W-1-b] = o_PIC_DO;
      else if (o_PIC_DO !== 1'b0) do_tail_zero = 1'b0;
      if (o_busy !== 1'b1) busy_ok = 1'b0;
      if (simul_end && b == nfalls - 1) begin
        i_PIC_SC = 1'b0;
        i_PIC_CS = 1'b1;
      end else begin
        i_PIC_SC = 1'b0;
        wait_cyc(HALF);
        i_PIC_SC = 1'b1;
        wait_cyc(HALF / 2);
        if (glitch && b == 7) begin
          i_PIC_SC = 1'b0;
          wait_cyc(2);
          i_PIC_SC = 1'b1;
          wait_cyc(HALF / 2);
        end
      end
    end
    if (!simul_end) begin
      wait_cyc(HALF / 2);
      i_PIC_CS = 1'b1;
    end
    nvalid = 0; nerr = 0; first_off = -1;
    for (int c = 1; c <= obs; c++) begin
      wait_cyc(1);
      if (o_rx_valid === 1'b1) begin nvalid++; if (first_off < 0) first_off = c; end
      if (o_frame_err === 1'b1) begin nerr++; if (first_off < 0) first_off = c; end
    end
    i_PIC_SC = 1'b1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0;
    wait_cyc(4);
    vectors++;
    if ({o_PIC_DO, o_rx_valid, o_frame_err, o_busy} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got DO/valid/err/busy=%b expected 0000",
               {o_PIC_DO, o_rx_valid, o_frame_err, o_busy});
    end
    vectors++;
    if (o_rx_data !== '0) begin
      miscompares++;
      $display("FAIL reset_rx_data: got %h expected 0000", o_rx_data);
    end
    i_rst_n = 1'b1;
    wait_cyc(2 * LAT + 4);
    vectors++;
    if (o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle_busy: got %b expected 0", o_busy);
    end
  endtask

  // Checks a frame outcome against the specification's rules: only a frame of
  // exactly WORD_W SC falls is accepted, DO carries tx MSB-first then zeros.
  task automatic check_frame(input string name, input logic [WORD_W-1:0] tx,
                             input logic [WORD_W-1:0] rx_word, input int eff_falls,
                             input int sent_falls, input bit chk_do, input bit chk_busy,
                             input logic [WORD_W-1:0] do_word, input bit do_tail_zero,
                             input bit busy_ok, input int nvalid, input int nerr,
                             input int first_off);
    logic [WORD_W-1:0] mask;
    bit good;
    good = (eff_falls == WORD_W);
    if (good) exp_rx = rx_word;
    mask = '0;
    for (int i = 0; i < sent_falls && i < WORD_W; i++) mask[WORD_W-1-i] = 1'b1;
    vectors++;
    if (nvalid !== (good ? 1 : 0) || nerr !== (good ? 0 : 1)) begin
      miscompares++;
      $display("FAIL %s_strobes: got valid=%0d err=%0d expected valid=%0d err=%0d",
               name, nvalid, nerr, good ? 1 : 0, good ? 0 : 1);
    end
    vectors++;
    if (first_off !== LAT) begin
      miscompares++;
      $display("FAIL %s_latency: got %0d cycles expected %0d", name, first_off, LAT);
    end
    vectors++;
    if (o_rx_data !== exp_rx) begin
      miscompares++;
      $display("FAIL %s_rx_data: got %h expected %h", name, o_rx_data, exp_rx);
    end
    if (chk_do) begin
      vectors++;
      if ((do_word & mask) !== (tx & mask) || do_tail_zero !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_do: got %h tail_zero=%b expected %h (mask %h) tail_zero=1",
                 name, do_word & mask, do_tail_zero, tx & mask, mask);
      end
    end
    if (chk_busy) begin
      vectors++;
      if (busy_ok !== 1'b1) begin
        miscompares++;
        $display("FAIL %s_busy: got busy low mid-frame expected high", name);
      end
    end
  endtask

  logic [WORD_W-1:0] dw;
  bit tz, bz;
  int nv, ne, off;

  task automatic test_nominal;
    run_frame(16'hA5C3, 16'h1234, 16, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("nominal", 16'hA5C3, 16'h1234, 16, 16, 1, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_short;
    run_frame(16'h5A5A, 16'hBEEF, 9, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("short", 16'h5A5A, 16'hBEEF, 9, 9, 1, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_long;
    run_frame(16'h3C3C, 16'hCAFE, 18, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("long", 16'h3C3C, 16'hCAFE, 18, 18, 1, 1, dw, tz, bz, nv, ne, off);
    run_frame(16'h0001, 16'hFFFF, 16, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("after_long", 16'h0001, 16'hFFFF, 16, 16, 1, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_reset_mid_frame;
    run_frame(16'h1111, 16'h7777, 16, 0, 0, 5, 4 * LAT, dw, tz, bz, nv, ne, off);
    exp_rx = '0;   // reset clears the received word
    vectors++;
    if (nv !== 0 || ne !== 0) begin
      miscompares++;
      $display("FAIL rst_mid_strobes: got valid=%0d err=%0d expected 0 0", nv, ne);
    end
    vectors++;
    if (o_rx_data !== exp_rx) begin
      miscompares++;
      $display("FAIL rst_mid_rx_data: got %h expected %h", o_rx_data, exp_rx);
    end
    run_frame(16'h9876, 16'h00FF, 16, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("after_rst", 16'h9876, 16'h00FF, 16, 16, 1, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_glitch;
    int eff;
`ifdef PIC_SPI_TGT_GLITCH_FILTER_EN
    eff = 16;
`else
    eff = 17;
`endif
    run_frame(16'h4242, 16'h8001, 16, 1, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("glitch", 16'h4242, 16'h8001, eff, 16, 0, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_simultaneous;
    // Last SC fall lands with CS rise and is ignored: 15 bits counted.
    run_frame(16'hF00D, 16'h2468, 16, 0, 1, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("simul15", 16'hF00D, 16'h2468, 15, 16, 1, 1, dw, tz, bz, nv, ne, off);
    // One extra fall merged with CS rise: exactly 16 counted.
    run_frame(16'hD00F, 16'h1357, 17, 0, 1, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("simul16", 16'hD00F, 16'h1357, 16, 17, 1, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_back_to_back;
    run_frame(16'hAAAA, 16'h0F0F, 16, 0, 0, -1, LAT + 1, dw, tz, bz, nv, ne, off);
    check_frame("b2b_first", 16'hAAAA, 16'h0F0F, 16, 16, 1, 1, dw, tz, bz, nv, ne, off);
    run_frame(16'h5555, 16'hF0F0, 16, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
    check_frame("b2b_second", 16'h5555, 16'hF0F0, 16, 16, 1, 1, dw, tz, bz, nv, ne, off);
  endtask

  task automatic test_random;
    logic [WORD_W-1:0] tx, rw;
    int nf;
    for (int k = 0; k < 20; k++) begin
      tx = WORD_W'($urandom);
      rw = WORD_W'($urandom);
      nf = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : WORD_W;
      run_frame(tx, rw, nf, 0, 0, -1, 4 * LAT, dw, tz, bz, nv, ne, off);
      check_frame("random", tx, rw, nf, nf, 1, nf > 0, dw, tz, bz, nv, ne, off);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_short();
    test_long();
    test_reset_mid_frame();
    test_glitch();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
